// File: rtl/execute_mdu_pkg.sv
// Shared types for the EX-stage multiply/divide unit: funct3 op codes, FSM encodings
// and the operand-select constant for the register-file path.
package execute_mdu_pkg;

   typedef enum logic [2:0] {
      MDOP_MUL    = 3'b000,
      MDOP_MULH   = 3'b001,
      MDOP_MULHSU = 3'b010,
      MDOP_MULHU  = 3'b011,
      MDOP_DIV    = 3'b100,
      MDOP_DIVU   = 3'b101,
      MDOP_REM    = 3'b110,
      MDOP_REMU   = 3'b111
   } mdop_t;

   typedef logic [1:0] mdu_state_t;
   localparam mdu_state_t MDU_IDLE = 2'd0;
   localparam mdu_state_t MDU_MUL  = 2'd1;
   localparam mdu_state_t MDU_DIV  = 2'd2;
   localparam mdu_state_t MDU_DONE = 2'd3;

   localparam int unsigned MDU_FWD_RF = 0;

   function automatic logic mdop_a_signed(input mdop_t op);
      return (op == MDOP_MULH) || (op == MDOP_MULHSU) || (op == MDOP_DIV) || (op == MDOP_REM);
   endfunction

   function automatic logic mdop_b_signed(input mdop_t op);
      return (op == MDOP_MULH) || (op == MDOP_DIV) || (op == MDOP_REM);
   endfunction

endpackage

// File: rtl/execute_mdu_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done is combinational on the final step; quotient/remainder carry that step's values.
module mdu_divider
   import execute_mdu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int unsigned CW = $clog2(XLEN);

   logic            busy;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] q;
   logic [XLEN-1:0] r;
   logic [XLEN-1:0] d;
   logic [XLEN:0]   r_shift;
   logic [XLEN:0]   diff;

   always_comb begin
      r_shift = {r, q[XLEN-1]};
      diff    = r_shift - {1'b0, d};
      if (!diff[XLEN]) begin
         remainder = diff[XLEN-1:0];
         quotient  = {q[XLEN-2:0], 1'b1};
      end else begin
         remainder = r_shift[XLEN-1:0];
         quotient  = {q[XLEN-2:0], 1'b0};
      end
      done = busy && (cnt == CW'(XLEN-1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= 1'b0;
         cnt  <= '0;
         q    <= '0;
         r    <= '0;
         d    <= '0;
      end else if (abort) begin
         busy <= 1'b0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= '0;
         q    <= dividend;
         r    <= '0;
         d    <= divisor;
      end else if (busy) begin
         q   <= quotient;
         r   <= remainder;
         cnt <= cnt + CW'(1);
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/execute_mdu.sv
// RV32M multiply/divide unit in EX with forwarding-aware operand select and stall handshake.
// Define EXECUTE_MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
module execute_mdu
   import execute_mdu_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NUM_FWD = 2,
   parameter int unsigned SELW    = $clog2(NUM_FWD+1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  logic [2:0]              mdop_in,
   input  logic [4:0]              rd_in,
   input  logic [XLEN-1:0]         rs1_data,
   input  logic [XLEN-1:0]         rs2_data,
   input  logic [NUM_FWD*XLEN-1:0] fwd_data,
   input  logic [SELW-1:0]         fwd1_sel,
   input  logic [SELW-1:0]         fwd2_sel,
   output logic                    valid_out,
   input  logic                    ready_in,
   output logic [XLEN-1:0]         result,
   output logic [4:0]              rd_out
);

   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] pick(input logic [SELW-1:0] sel,
                                            input logic [XLEN-1:0] rf,
                                            input logic [NUM_FWD*XLEN-1:0] fwd);
      logic [XLEN-1:0] v;
      v = '0;
      if (sel == SELW'(MDU_FWD_RF)) v = rf;
      for (int unsigned k = 0; k < NUM_FWD; k++)
         if (sel == SELW'(k+1)) v = fwd[k*XLEN +: XLEN];
      return v;
   endfunction

   // Product is formed on magnitudes; sign is restored before picking the half.
   function automatic logic [XLEN-1:0] mul_pick(input mdop_t op, input logic neg,
                                                input logic [2*XLEN-1:0] p);
      logic [2*XLEN-1:0] f;
      f = neg ? -p : p;
      return (op == MDOP_MUL) ? f[XLEN-1:0] : f[2*XLEN-1:XLEN];
   endfunction

   mdu_state_t      state;
   mdop_t           op;
   mdop_t           op_q;
   logic            sa_q, sb_q;
   logic [XLEN-1:0] op_a, op_b, mag_a, mag_b;
   logic            sa, sb;
   logic            div_zero, div_ovf, special, accept, div_start;
   logic [XLEN-1:0] special_res;
   logic            div_done;
   logic [XLEN-1:0] div_quo, div_rem, div_res;

   assign ready_out = (state == MDU_IDLE);
   assign valid_out = (state == MDU_DONE);

   always_comb begin
      op          = mdop_t'(mdop_in);
      op_a        = pick(fwd1_sel, rs1_data, fwd_data);
      op_b        = pick(fwd2_sel, rs2_data, fwd_data);
      sa          = mdop_a_signed(op) & op_a[XLEN-1];
      sb          = mdop_b_signed(op) & op_b[XLEN-1];
      mag_a       = sa ? -op_a : op_a;
      mag_b       = sb ? -op_b : op_b;
      div_zero    = (op_b == '0);
      div_ovf     = mdop_b_signed(op) && (op_a == XMIN) && (op_b == '1);
      special     = mdop_in[2] && (div_zero || div_ovf);
      special_res = '0;
      if (div_zero)     special_res = mdop_in[1] ? op_a : '1;
      else if (div_ovf) special_res = mdop_in[1] ? '0 : XMIN;
      accept      = valid_in && ready_out && !flush;
      div_start   = accept && mdop_in[2] && !special;
   end

   mdu_divider #(.XLEN(XLEN)) u_divider (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .abort     (flush),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_comb begin
      if (op_q[1]) div_res = sa_q ? -div_rem : div_rem;
      else         div_res = (sa_q ^ sb_q) ? -div_quo : div_quo;
   end

`ifdef EXECUTE_MDU_FAST_MUL_EN
   logic [2*XLEN-1:0] prod_fast;
   assign prod_fast = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
`else
   localparam int unsigned CW = $clog2(XLEN);
   logic [2*XLEN-1:0] mcand, acc, acc_n;
   logic [XLEN-1:0]   mplier;
   logic [CW-1:0]     cnt;
   assign acc_n = acc + (mplier[0] ? mcand : '0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= MDU_IDLE;
         result <= '0;
         rd_out <= '0;
         op_q   <= MDOP_MUL;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
`ifndef EXECUTE_MDU_FAST_MUL_EN
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
`endif
      end else if (flush) begin
         state <= MDU_IDLE;
      end else begin
         case (state)
            MDU_IDLE: begin
               if (accept) begin
                  rd_out <= rd_in;
                  op_q   <= op;
                  sa_q   <= sa;
                  sb_q   <= sb;
                  if (special) begin
                     result <= special_res;
                     state  <= MDU_DONE;
                  end else if (mdop_in[2]) begin
                     state  <= MDU_DIV;
                  end else begin
`ifdef EXECUTE_MDU_FAST_MUL_EN
                     result <= mul_pick(op, sa ^ sb, prod_fast);
                     state  <= MDU_DONE;
`else
                     mcand  <= (2*XLEN)'(mag_a);
                     mplier <= mag_b;
                     acc    <= '0;
                     cnt    <= '0;
                     state  <= MDU_MUL;
`endif
                  end
               end
            end
            MDU_MUL: begin
`ifdef EXECUTE_MDU_FAST_MUL_EN
               state <= MDU_IDLE;
`else
               acc    <= acc_n;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(XLEN-1)) begin
                  result <= mul_pick(op_q, sa_q ^ sb_q, acc_n);
                  state  <= MDU_DONE;
               end
`endif
            end
            MDU_DIV: begin
               if (div_done) begin
                  result <= div_res;
                  state  <= MDU_DONE;
               end
            end
            MDU_DONE: begin
               if (ready_in) state <= MDU_IDLE;
            end
            default: state <= MDU_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_mdu.sv
// Self-checking bench for execute_mdu: vector table through a scoreboard, plus
// hand sequences for backpressure, flush and mid-operation reset.
module tb_execute_mdu;
   import execute_mdu_pkg::*;

   localparam int XLEN    = 32;
   localparam int NUM_FWD = 2;
`ifdef EXECUTE_MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = XLEN + 1;
`endif
   localparam int DIV_LAT = XLEN + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        valid_in = 1'b0;
   logic        ready_out;
   logic [2:0]  mdop_in = '0;
   logic [4:0]  rd_in = '0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic [63:0] fwd_data = '0;
   logic [1:0]  fwd1_sel = '0;
   logic [1:0]  fwd2_sel = '0;
   logic        valid_out;
   logic        ready_in = 1'b1;
   logic [31:0] result;
   logic [4:0]  rd_out;

   execute_mdu #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
      .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_out(ready_out),
      .mdop_in(mdop_in), .rd_in(rd_in), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .fwd_data(fwd_data), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
      .valid_out(valid_out), .ready_in(ready_in), .result(result), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      mdop_t       op;
      logic [31:0] a, b, f0, f1;
      logic [1:0]  s1, s2;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          lat;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   pass_cnt = 0;
   int   total = 0;

   function automatic vec_t mk(mdop_t op, logic [31:0] a, logic [31:0] b, logic [1:0] s1,
                               logic [1:0] s2, logic [31:0] f0, logic [31:0] f1,
                               logic [31:0] exp, int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.s1 = s1; v.s2 = s2; v.f0 = f0; v.f1 = f1;
      v.exp = exp; v.lat = lat;
      return v;
   endfunction

   function automatic logic [31:0] ref_res(mdop_t op, logic [31:0] a, logic [31:0] b);
      int          ai, bi;
      longint      pa, pb;
      logic [63:0] p;
      logic [31:0] r;
      ai = a; bi = b; r = '0;
      case (op)
         MDOP_MUL:    begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
         MDOP_MULH:   begin pa = longint'(ai); pb = longint'(bi); p = pa * pb; r = p[63:32]; end
         MDOP_MULHSU: begin pa = longint'(ai); pb = longint'({32'b0, b}); p = pa * pb; r = p[63:32]; end
         MDOP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
         MDOP_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ai / bi);
         MDOP_REM:    r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ai % bi);
         MDOP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         MDOP_REMU:   r = (b == 0) ? a : a % b;
         default:     r = '0;
      endcase
      return r;
   endfunction

   function automatic int ref_lat(mdop_t op, logic [31:0] a, logic [31:0] b);
      logic sdiv;
      sdiv = (op == MDOP_DIV) || (op == MDOP_REM);
      if (!op[2]) return MUL_LAT;
      if (b == 0 || (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return DIV_LAT;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input vec_t v, input logic [4:0] rd);
      @(negedge clk);
      mdop_in  = v.op;
      rs1_data = v.a;
      rs2_data = v.b;
      fwd_data = {v.f1, v.f0};
      fwd1_sel = v.s1;
      fwd2_sel = v.s2;
      rd_in    = rd;
      valid_in = 1'b1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!valid_out && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input vec_t v, input logic [4:0] rd, input string name);
      int  lat;
      sb_t e;
      drive(v, rd);
      sb.push_back('{res: v.exp, rd: rd, lat: v.lat});
      @(posedge clk); #1;
      valid_in = 1'b0;
      chk({name, "_busy"}, 32'(ready_out), 32'd0);
      wait_valid(lat);
      if (!valid_out) begin
         chk({name, "_timeout"}, 32'(valid_out), 32'd1);
      end else if (sb.size() == 0) begin
         chk({name, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         chk({name, "_result"}, result, e.res);
         chk({name, "_rd"}, 32'(rd_out), 32'(e.rd));
         chk({name, "_latency"}, 32'(lat), 32'(e.lat));
      end
      @(posedge clk); #1;
      chk({name, "_ready_after"}, 32'(ready_out), 32'd1);
   endtask

   initial begin
      int   lat;
      logic seen;
      vec_t v;

      vecs.push_back(mk(MDOP_MUL,    32'd7,         32'hFFFF_FFFD, 2'd0, 2'd0, 32'h0,         32'h0, 32'hFFFF_FFEB, MUL_LAT));
      vecs.push_back(mk(MDOP_MULHU,  32'hFFFF_FFFF, 32'h1234_5678, 2'd0, 2'd1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, MUL_LAT));
      vecs.push_back(mk(MDOP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 2'd0, 32'h0,         32'h0, 32'h0000_0000, MUL_LAT));
      vecs.push_back(mk(MDOP_MULH,   32'h8000_0000, 32'h8000_0000, 2'd0, 2'd0, 32'h0,         32'h0, 32'h4000_0000, MUL_LAT));
      vecs.push_back(mk(MDOP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 2'd0, 32'h0,         32'h0, 32'hFFFF_FFFF, MUL_LAT));
      vecs.push_back(mk(MDOP_MUL,    32'hDEAD_BEEF, 32'd7,         2'd2, 2'd0, 32'h0,         32'd6, 32'd42,        MUL_LAT));
      vecs.push_back(mk(MDOP_MUL,    32'd9,         32'd5,         2'd3, 2'd0, 32'h1,         32'h2, 32'd0,         MUL_LAT));
      vecs.push_back(mk(MDOP_DIV,    32'hFFFF_FFF9, 32'd2,         2'd0, 2'd0, 32'h0,         32'h0, 32'hFFFF_FFFD, DIV_LAT));
      vecs.push_back(mk(MDOP_REM,    32'hFFFF_FFF9, 32'd2,         2'd0, 2'd0, 32'h0,         32'h0, 32'hFFFF_FFFF, DIV_LAT));
      vecs.push_back(mk(MDOP_DIV,    32'd7,         32'hFFFF_FFFE, 2'd0, 2'd0, 32'h0,         32'h0, 32'hFFFF_FFFD, DIV_LAT));
      vecs.push_back(mk(MDOP_REM,    32'd7,         32'hFFFF_FFFE, 2'd0, 2'd0, 32'h0,         32'h0, 32'd1,         DIV_LAT));
      vecs.push_back(mk(MDOP_DIVU,   32'd5,         32'd0,         2'd0, 2'd0, 32'h0,         32'h0, 32'hFFFF_FFFF, 1));
      vecs.push_back(mk(MDOP_REM,    32'd5,         32'd0,         2'd0, 2'd0, 32'h0,         32'h0, 32'd5,         1));
      vecs.push_back(mk(MDOP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 2'd0, 32'h0,         32'h0, 32'h8000_0000, 1));
      vecs.push_back(mk(MDOP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 2'd0, 32'h0,         32'h0, 32'd0,         1));
      vecs.push_back(mk(MDOP_DIVU,   32'hFFFF_FFFF, 32'd3,         2'd0, 2'd0, 32'h0,         32'h0, 32'h5555_5555, DIV_LAT));
      vecs.push_back(mk(MDOP_REMU,   32'd100,       32'd7,         2'd0, 2'd0, 32'h0,         32'h0, 32'd2,         DIV_LAT));
      vecs.push_back(mk(MDOP_DIV,    32'd9,         32'd4,         2'd0, 2'd3, 32'h0,         32'h0, 32'hFFFF_FFFF, 1));
      for (int i = 0; i < 8; i++) begin
         v.op = mdop_t'(3'($urandom_range(0, 7)));
         v.a  = $urandom;
         v.b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
         v.s1 = 2'd0; v.s2 = 2'd0; v.f0 = '0; v.f1 = '0;
         v.exp = ref_res(v.op, v.a, v.b);
         v.lat = ref_lat(v.op, v.a, v.b);
         vecs.push_back(v);
      end

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rd_out", 32'(rd_out), 32'd0);
      chk("rst_ready_out", 32'(ready_out), 32'd1);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) run_op(vecs[i], 5'(i + 1), $sformatf("vec%0d", i));

      // backpressure: result held while ready_in is low
      ready_in = 1'b0;
      drive(mk(MDOP_DIVU, 32'd100, 32'd7, 2'd0, 2'd0, 32'h0, 32'h0, 32'd14, DIV_LAT), 5'd9);
      @(posedge clk); #1;
      valid_in = 1'b0;
      wait_valid(lat);
      chk("hold_latency", 32'(lat), 32'(DIV_LAT));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rs1_data = $urandom;
         @(posedge clk); #1;
         chk("hold_result", result, 32'd14);
         chk("hold_valid", 32'(valid_out), 32'd1);
      end
      chk("hold_rd", 32'(rd_out), 32'd9);
      @(negedge clk);
      ready_in = 1'b1;
      @(posedge clk); #1;
      chk("hold_release", 32'(valid_out), 32'd0);

      // flush during a divide
      drive(mk(MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0), 5'd3);
      @(posedge clk); #1;
      valid_in = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_ready", 32'(ready_out), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         seen = seen | valid_out;
      end
      chk("flush_no_valid", 32'(seen), 32'd0);
      run_op(mk(MDOP_DIV, 32'd1000, 32'd10, 2'd0, 2'd0, 32'h0, 32'h0, 32'd100, DIV_LAT), 5'd4, "post_flush");

      // flush and valid_in together: nothing accepted
      drive(mk(MDOP_DIVU, 32'd5, 32'd0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0), 5'd5);
      flush = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      flush = 1'b0;
      chk("flush_vs_valid_ready", 32'(ready_out), 32'd1);
      chk("flush_vs_valid_out", 32'(valid_out), 32'd0);

      // flush beats ready_in while a result is waiting
      ready_in = 1'b0;
      drive(mk(MDOP_DIVU, 32'd5, 32'd0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0), 5'd6);
      @(posedge clk); #1;
      valid_in = 1'b0;
      chk("done_before_flush", 32'(valid_out), 32'd1);
      @(negedge clk);
      flush = 1'b1;
      ready_in = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_in_done", 32'(valid_out), 32'd0);

      // async reset in the middle of a multiply
      drive(mk(MDOP_MUL, 32'd7, 32'hFFFF_FFFD, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0), 5'd7);
      @(posedge clk); #1;
      valid_in = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_valid", 32'(valid_out), 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_rd", 32'(rd_out), 32'd0);
      chk("midrst_ready", 32'(ready_out), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      run_op(mk(MDOP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 2'd0, 32'h0, 32'h0, 32'hFFFF_FFFE, MUL_LAT), 5'd8, "post_rst");

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
